// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared constants for the UART Rx read scheduler: FSM encodings,
//            FIFO word error-bit positions and default widths.
// Revision : 1.0
// ============================================================================
package uart_rx_pkg;

  localparam int WORD_W_DEF  = 12;
  localparam int DATA_W_DEF  = 9;

  localparam int PAR_ERR_BIT = 9;
  localparam int FRM_ERR_BIT = 10;
  localparam int BRK_ERR_BIT = 11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_POP  = 3'd1;
  localparam state_t ST_CAPT = 3'd2;
  localparam state_t ST_RESP = 3'd3;
  localparam state_t ST_DONE = 3'd4;
  localparam state_t ST_WAIT = 3'd5;

  // Position of each error flag inside the sticky status vector
  typedef enum logic [1:0] {
    ERR_PAR = 2'd0,
    ERR_FRM = 2'd1,
    ERR_BRK = 2'd2
  } err_idx_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_read_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_read_sched_if
// Brief    : APB read-side bus bundle between slave decode and Rx scheduler.
// Revision : 1.0
// ============================================================================
interface uart_rx_read_sched_if #(
  parameter int DATA_W = 9
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sat_cnt
// Brief    : Saturating event counter; a clear and an increment on the same
//            edge yield a count of one.
// Revision : 1.0
// ============================================================================
module uart_rx_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  wire logic             baud_clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  input  wire logic             i_clr,
  output logic      [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_base;

  assign w_base = i_clr ? '0 : r_cnt;

  always_ff @(posedge baud_clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_inc && !(&w_base)) begin
      r_cnt <= w_base + 1'b1;
    end else begin
      r_cnt <= w_base;
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/uart_rx_read_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_read_sched
// Brief    : Turns APB reads into single Rx FIFO pops, returns data+parity and
//            tracks sticky/counted line errors. Optional macro RX_WAIT_EN adds
//            a bounded wait for data when the FIFO is empty.
// Revision : 1.0
// ============================================================================
module uart_rx_read_sched
  import uart_rx_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  wire logic              baud_clk,
  input  wire logic              rst,
  uart_rx_read_sched_if.slave    apb,
  input  wire logic [WORD_W-1:0] i_rx_word,
  input  wire logic              i_rx_empty,
  input  wire logic              i_err_clr,
  output logic                   o_rx_pop,
  output logic       [2:0]       o_err_sticky,
  output logic       [CNT_W-1:0] o_par_cnt,
  output logic       [CNT_W-1:0] o_frm_cnt,
  output logic       [CNT_W-1:0] o_brk_cnt
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pslverr;
  logic [2:0]        r_sticky;
  logic              w_req;
  logic              w_capt;
  logic              w_empty_err;
  logic [2:0]        w_err_bits;

  assign w_req      = apb.psel & apb.penable & ~apb.pwrite;
  assign w_capt     = (r_state == ST_CAPT);
  assign w_err_bits = i_rx_word[BRK_ERR_BIT:PAR_ERR_BIT];

`ifdef RX_WAIT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] r_wait_cnt;
  logic          w_timeout;

  assign w_timeout   = (r_wait_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_empty_err = (r_state == ST_WAIT) && w_req && i_rx_empty && w_timeout;

  always_ff @(posedge baud_clk) begin
    if (!rst || r_state != ST_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  assign w_empty_err = (r_state == ST_IDLE) && w_req && i_rx_empty;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !i_rx_empty) begin
          w_state_nxt = ST_POP;
        end else if (w_req) begin
`ifdef RX_WAIT_EN
          w_state_nxt = ST_WAIT;
`else
          w_state_nxt = ST_RESP;
`endif
        end
      end
`ifdef RX_WAIT_EN
      // Abandonment takes priority so a withdrawn read never pops
      ST_WAIT: begin
        if (!w_req)          w_state_nxt = ST_IDLE;
        else if (!i_rx_empty) w_state_nxt = ST_POP;
        else if (w_timeout)  w_state_nxt = ST_RESP;
      end
`endif
      ST_POP:  w_state_nxt = ST_CAPT;
      ST_CAPT: w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_DONE;
      ST_DONE: if (!(apb.psel && apb.penable)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      r_sticky  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      // Clear first, then merge fresh capture bits so they survive a coincident clear
      r_sticky <= (i_err_clr ? 3'b000 : r_sticky) | (w_capt ? w_err_bits : 3'b000);
      if (w_capt) begin
        r_prdata  <= i_rx_word[DATA_W-1:0];
        r_pslverr <= |w_err_bits;
      end else if (w_empty_err) begin
        r_prdata  <= '0;
        r_pslverr <= 1'b1;
      end
    end
  end

  uart_rx_sat_cnt #(.CNT_W(CNT_W)) u_par_cnt (
    .baud_clk (baud_clk),
    .rst      (rst),
    .i_inc    (w_capt & w_err_bits[ERR_PAR]),
    .i_clr    (i_err_clr),
    .o_cnt    (o_par_cnt)
  );

  uart_rx_sat_cnt #(.CNT_W(CNT_W)) u_frm_cnt (
    .baud_clk (baud_clk),
    .rst      (rst),
    .i_inc    (w_capt & w_err_bits[ERR_FRM]),
    .i_clr    (i_err_clr),
    .o_cnt    (o_frm_cnt)
  );

  uart_rx_sat_cnt #(.CNT_W(CNT_W)) u_brk_cnt (
    .baud_clk (baud_clk),
    .rst      (rst),
    .i_inc    (w_capt & w_err_bits[ERR_BRK]),
    .i_clr    (i_err_clr),
    .o_cnt    (o_brk_cnt)
  );

  assign o_rx_pop     = (r_state == ST_POP);
  assign apb.pready   = (r_state == ST_RESP);
  assign apb.pslverr  = r_pslverr & (r_state == ST_RESP);
  assign apb.prdata   = r_prdata;
  assign o_err_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_read_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_read_sched
// Brief    : Scoreboard bench for uart_rx_read_sched with a queue-based FIFO model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_read_sched;

  typedef struct packed {
    logic       err;
    logic [8:0] data;
  } rsp_t;

  logic        baud_clk = 1'b0;
  logic        rst      = 1'b0;
  logic [11:0] rx_word  = '0;
  logic        rx_empty = 1'b1;
  logic        err_clr  = 1'b0;
  logic        rx_pop;
  logic [2:0]  err_sticky;
  logic [7:0]  par_cnt, frm_cnt, brk_cnt;

  uart_rx_read_sched_if #(.DATA_W(9)) apb ();

  uart_rx_read_sched #(.WORD_W(12), .DATA_W(9), .CNT_W(8), .TIMEOUT_CYC(16)) dut (
    .baud_clk     (baud_clk),
    .rst          (rst),
    .apb          (apb.slave),
    .i_rx_word    (rx_word),
    .i_rx_empty   (rx_empty),
    .i_err_clr    (err_clr),
    .o_rx_pop     (rx_pop),
    .o_err_sticky (err_sticky),
    .o_par_cnt    (par_cnt),
    .o_frm_cnt    (frm_cnt),
    .o_brk_cnt    (brk_cnt)
  );

  always #5 baud_clk = ~baud_clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          pop_edge = 0;
  int          ready_edge = 0;
  int          req_edge = 0;
  bit          ready_seen = 0;
  bit          pop_pending = 0;
  bit          last_pop = 0;
  logic [11:0] fifo_q[$];
  rsp_t        exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: word appears on the edge that ends the pop cycle
  always @(posedge baud_clk) begin
    cyc++;
    if (pop_pending) begin
      if (fifo_q.size() > 0) rx_word <= fifo_q.pop_front();
      pop_pending = 0;
    end
  end

  // Monitor: pop bookkeeping and response scoreboard
  always @(negedge baud_clk) begin
    rx_empty = (fifo_q.size() == 0);
    if (rst && rx_pop) begin
      pop_cnt++;
      pop_edge = cyc + 1;
      chk("pop_back_to_back", {31'd0, last_pop}, 32'd0);
      chk("pop_while_empty", {31'd0, fifo_q.size() == 0}, 32'd0);
      pop_pending = 1;
    end
    last_pop = rx_pop;
    if (rst && apb.pready) begin
      rsp_t e;
      ready_seen = 1;
      ready_edge = cyc + 1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: got pready=1 expected no response");
      end else begin
        e = exp_q.pop_front();
        chk("prdata", {23'd0, apb.prdata}, {23'd0, e.data});
        chk("pslverr", {31'd0, apb.pslverr}, {31'd0, e.err});
      end
    end
  end

  task automatic apb_read(input logic [8:0] d, input logic e, input int hold,
                          input int exp_pops, input bit lat);
    int p0;
    bit got;
    exp_q.push_back('{err: e, data: d});
    p0  = pop_cnt;
    got = 0;
    @(negedge baud_clk);
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0;
    @(negedge baud_clk);
    ready_seen  = 0;
    apb.penable = 1'b1;
    req_edge    = cyc + 1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge baud_clk);
      if (ready_seen) got = 1;
    end
    chk("pready_timeout", {31'd0, got}, 32'd1);
    repeat (hold) @(negedge baud_clk);
    @(negedge baud_clk);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge baud_clk);
    chk("pop_count", pop_cnt - p0, exp_pops);
    if (lat) begin
      chk("pop_latency", pop_edge - req_edge, 32'd1);
      chk("pready_latency", ready_edge - req_edge, 32'd3);
    end
  endtask

  task automatic wait_pop(output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge baud_clk);
      if (rx_pop) found = 1;
    end
  endtask

  task automatic chk_status(input logic [2:0] st, input logic [7:0] p,
                            input logic [7:0] f, input logic [7:0] b);
    chk("err_sticky", {29'd0, err_sticky}, {29'd0, st});
    chk("par_cnt", {24'd0, par_cnt}, {24'd0, p});
    chk("frm_cnt", {24'd0, frm_cnt}, {24'd0, f});
    chk("brk_cnt", {24'd0, brk_cnt}, {24'd0, b});
  endtask

  initial begin
    bit found;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    repeat (3) @(negedge baud_clk);
    chk("rst_rx_pop", {31'd0, rx_pop}, 32'd0);
    chk("rst_pready", {31'd0, apb.pready}, 32'd0);
    chk("rst_pslverr", {31'd0, apb.pslverr}, 32'd0);
    chk("rst_prdata", {23'd0, apb.prdata}, 32'd0);
    chk_status(3'b000, 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    @(negedge baud_clk);

    // Clean word with latency checks
    fifo_q.push_back(12'h0A5);
    apb_read(9'h0A5, 1'b0, 0, 1, 1'b1);
    chk_status(3'b000, 8'h00, 8'h00, 8'h00);

    // Frame + parity error word
    fifo_q.push_back(12'h63C);
    apb_read(9'h03C, 1'b1, 0, 1, 1'b0);
    chk_status(3'b011, 8'h01, 8'h01, 8'h00);

    // A write must not pop
    fifo_q.push_back(12'h011);
    @(negedge baud_clk);
    apb.psel = 1'b1; apb.pwrite = 1'b1;
    @(negedge baud_clk);
    apb.penable = 1'b1;
    repeat (4) @(negedge baud_clk);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    chk("write_no_pop", fifo_q.size(), 32'd1);
    apb_read(9'h011, 1'b0, 0, 1, 1'b0);

`ifdef RX_WAIT_EN
    // Data arrives while waiting
    fork
      apb_read(9'h123, 1'b0, 0, 1, 1'b0);
      begin
        repeat (5) @(negedge baud_clk);
        fifo_q.push_back(12'h123);
      end
    join
    // Never arrives: timeout error response
    apb_read(9'h000, 1'b1, 0, 0, 1'b0);
    chk("timeout_latency", ready_edge - req_edge, 32'd17);
`else
    apb_read(9'h000, 1'b1, 0, 0, 1'b0);
    chk("empty_latency", ready_edge - req_edge, 32'd1);
`endif

    // Held access phase after pready still yields one pop
    fifo_q.push_back(12'h055);
    apb_read(9'h055, 1'b0, 6, 1, 1'b0);

    // 256 break words saturate the break counter
    for (int i = 0; i < 256; i++) begin
      logic [11:0] w;
      w = 12'h800 | 12'(i);
      fifo_q.push_back(w);
      apb_read(w[8:0], 1'b1, 0, 1, 1'b0);
    end
    chk_status(3'b111, 8'h01, 8'h01, 8'hFF);

    // Standalone clear
    @(negedge baud_clk) err_clr = 1'b1;
    @(negedge baud_clk) err_clr = 1'b0;
    @(negedge baud_clk);
    chk_status(3'b000, 8'h00, 8'h00, 8'h00);

    fifo_q.push_back(12'h400);
    apb_read(9'h000, 1'b1, 0, 1, 1'b0);
    chk_status(3'b010, 8'h00, 8'h01, 8'h00);

    // Clear coincident with capture of a parity-error word
    fifo_q.push_back(12'h2AA);
    fork
      apb_read(9'h0AA, 1'b1, 0, 1, 1'b0);
      begin
        wait_pop(found);
        chk("clr_pop_seen", {31'd0, found}, 32'd1);
        @(negedge baud_clk) err_clr = 1'b1;
        @(negedge baud_clk) err_clr = 1'b0;
      end
    join
    chk_status(3'b001, 8'h01, 8'h00, 8'h00);

    // Reset asserted during capture aborts the transfer
    fifo_q.push_back(12'h6FF);
    @(negedge baud_clk);
    apb.psel = 1'b1;
    @(negedge baud_clk);
    apb.penable = 1'b1;
    wait_pop(found);
    chk("rstcapt_pop_seen", {31'd0, found}, 32'd1);
    @(negedge baud_clk) rst = 1'b0;
    @(negedge baud_clk);
    chk("rstcapt_rx_pop", {31'd0, rx_pop}, 32'd0);
    chk("rstcapt_pready", {31'd0, apb.pready}, 32'd0);
    chk("rstcapt_pslverr", {31'd0, apb.pslverr}, 32'd0);
    chk("rstcapt_prdata", {23'd0, apb.prdata}, 32'd0);
    chk_status(3'b000, 8'h00, 8'h00, 8'h00);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge baud_clk) rst = 1'b1;
    repeat (4) @(negedge baud_clk);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
